fetch_stage: RTL

- Instruction-fetch stage of the vector processor pipeline; sits directly upstream of Decode_Stage.
- Owns the PC and drives a synchronous-read instruction memory.
- Holds the IF/ID pipeline register that delivers the 20-bit instruction word to decode.
- Handles decode stalls, pipeline flushes, execute-stage branch redirects and a HALT instruction.

---
 rtl/vp_pkg.sv | 28 ++
 rtl/fetch_stage_if.sv | 35 +++
 rtl/fetch_stage_pc_gen.sv | 47 ++++
 rtl/fetch_stage.sv | 102 ++++++++++
 4 files changed

// File: rtl/vp_pkg.sv
// vp_pkg: types and constants shared by the vector processor front end
// (fetch_stage, Decode_Stage).
//   PC_W / INSTR_W / CNT_W   default widths
//   NOP_INSTR / HALT_INSTR   special instruction encodings
//   fetch_state_t            fetch FSM states
//   ifid_t                   IF/ID pipeline register payload
package vp_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 20;
  localparam int CNT_W   = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR  = 20'h00000;
  localparam logic [INSTR_W-1:0] HALT_INSTR = 20'hFFFFF;

  typedef enum logic {FS_RUN, FS_HALT} fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic               valid;
  } ifid_t;

  function automatic logic is_halt(input logic [INSTR_W-1:0] word);
    return word == HALT_INSTR;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: pipeline-facing signals of the fetch stage.
//   stall, flush, br_taken, br_target   control from decode / execute
//   imem_addr, imem_rdata               sync-read instruction memory
//   instr, instr_pc, instr_valid        IF/ID register toward decode
//   halted, fetch_count                 status
// master = fetch_stage side, slave = surrounding pipeline / memory side.
interface fetch_stage_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 20,
  parameter int CNT_W   = 32
);

  logic               stall;
  logic               flush;
  logic               br_taken;
  logic [PC_W-1:0]    br_target;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_valid;
  logic               halted;
  logic [CNT_W-1:0]   fetch_count;

  modport master (
    input  stall, flush, br_taken, br_target, imem_rdata,
    output imem_addr, instr, instr_pc, instr_valid, halted, fetch_count
  );

  modport slave (
    output stall, flush, br_taken, br_target, imem_rdata,
    input  imem_addr, instr, instr_pc, instr_valid, halted, fetch_count
  );

endinterface

// File: rtl/fetch_stage_pc_gen.sv
// pc_gen: next-PC selection and the PC register.
//   clk, rst    clock, synchronous active-high reset
//   br_taken    redirect request, br_target is the new PC
//   hold        keep the current PC (halted or stalled)
//   pc          current PC; memory data for this address is on imem_rdata
//   next_pc     combinational next PC, drives the memory address
module pc_gen #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            hold,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  // rst is part of the mux so the memory sees RESET_PC during reset and
  // returns mem[RESET_PC] on the first cycle afterwards.
  always_comb begin
    pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    if (rst) begin
      pc_d = RESET_PC;
    end else if (br_taken) begin
      pc_d = br_target;
    end else if (hold) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc      = pc_q;
  assign next_pc = pc_d;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with IF/ID register, RUN/HALT FSM and a
// delivered-instruction counter.
//   clk, rst   clock, synchronous active-high reset
//   bus        fetch_stage_if.master: control in, memory port, IF/ID out
//
// state   | meaning
// FS_RUN  | fetching, PC advances unless stalled
// FS_HALT | HALT word delivered; PC frozen, bubbles until a redirect
module fetch_stage #(
  parameter int              PC_W     = vp_pkg::PC_W,
  parameter int              INSTR_W  = vp_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = vp_pkg::CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  import vp_pkg::fetch_state_t;
  import vp_pkg::FS_RUN;
  import vp_pkg::FS_HALT;

  localparam logic [INSTR_W-1:0] NOP_W  = '0;
  localparam logic [INSTR_W-1:0] HALT_W = '1;

  fetch_state_t       state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    next_pc;

  pc_gen #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk       (clk),
    .rst       (rst),
    .br_taken  (bus.br_taken),
    .br_target (bus.br_target),
    .hold      ((state_q == FS_HALT) || bus.stall),
    .pc        (pc),
    .next_pc   (next_pc)
  );

  assign bus.imem_addr = next_pc;

  // Squash beats halt beats stall beats load; only the load path can
  // enter HALT, and only a redirect leaves it.
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    count_d    = count_q;
    if (bus.br_taken || bus.flush) begin
      instr_d    = NOP_W;
      instr_pc_d = '0;
      valid_d    = 1'b0;
      if (bus.br_taken) begin
        state_d = FS_RUN;
      end
    end else if (state_q == FS_HALT) begin
      instr_d    = NOP_W;
      instr_pc_d = '0;
      valid_d    = 1'b0;
    end else if (!bus.stall) begin
      instr_d    = bus.imem_rdata;
      instr_pc_d = pc;
      valid_d    = 1'b1;
      count_d    = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (bus.imem_rdata == HALT_W) begin
        state_d = FS_HALT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FS_RUN;
      instr_q    <= NOP_W;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
    end
  end

  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.halted      = (state_q == FS_HALT);
  assign bus.fetch_count = count_q;

endmodule
